repetition_pattern_gen: RTL and testbench

//  Drives the a/b signal pair watched by the repetition monitors: consecutive runs (a[*N]) and

---
 rtl/repetition_pkg.sv | 27 ++
 rtl/rep_down_counter.sv | 28 ++
 rtl/repetition_pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_repetition_pattern_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/repetition_pkg.sv
// Shared types and constants for the repetition pattern generator.
// Holds the pattern kinds, the FSM state encoding and the minimum spacing values.
package repetition_pkg;

  typedef enum logic {
    CONSECUTIVE = 1'b0,
    GOTO        = 1'b1
  } repetition_kind_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_A   = 3'd1,
    PULSE_A = 3'd2,
    GAP     = 3'd3,
    PULSE_B = 3'd4,
    FINISH  = 3'd5
  } state_e;

  // The a->b spacing rule forbids b in the four cycles after a.
  localparam int unsigned MIN_AB_GAP = 4;
  localparam int unsigned MIN_BB_GAP = 1;

  function automatic int unsigned max_w(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/rep_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
// load has priority over dec; zero reflects the registered count.
module rep_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/repetition_pattern_gen.sv
// Stimulus source for the repetition monitors: emits a[*N] runs or a ##1 b[->M] goto patterns.
// Outputs are registered; first a appears the cycle after start, done pulses one cycle after the last a/b.
module repetition_pattern_gen
  import repetition_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  repetition_kind_e kind,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] b_count,
  input  logic [GAP_W-1:0] ab_gap,
  input  logic [GAP_W-1:0] bb_gap,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = max_w(LEN_W, GAP_W);

  generate
    if (GAP_W < 3) begin : g_gap_w_check
      $error("GAP_W must be at least 3 so that MIN_AB_GAP fits");
    end
  endgenerate

  localparam logic [GAP_W-1:0] AB_MIN = GAP_W'(MIN_AB_GAP);
  localparam logic [GAP_W-1:0] BB_MIN = GAP_W'(MIN_BB_GAP);

  state_e           state;
  logic [GAP_W-1:0] ab_eff;
  logic [GAP_W-1:0] bb_eff;
  logic [LEN_W-1:0] b_left;

  logic [GAP_W-1:0] ab_clamped;
  logic [GAP_W-1:0] bb_clamped;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CW-1:0]    cnt_val;
  logic             cnt_zero;

  assign ab_clamped = (ab_gap < AB_MIN) ? AB_MIN : ab_gap;
  assign bb_clamped = (bb_gap < BB_MIN) ? BB_MIN : bb_gap;

  // The shared counter is loaded with (length-1) on the edge that enters RUN_A or GAP,
  // so it reads zero during the last cycle of that phase.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (start && (kind == CONSECUTIVE) && (run_len != '0)) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(run_len) - CW'(1);
        end
      end
      PULSE_A: begin
        cnt_load = 1'b1;
        cnt_val  = CW'(ab_eff) - CW'(1);
      end
      RUN_A, GAP: begin
        cnt_dec = 1'b1;
      end
      PULSE_B: begin
        if (b_left != LEN_W'(1)) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(bb_eff) - CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  rep_down_counter #(
    .W (CW)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= 1'b0;
      b      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ab_eff <= '0;
      bb_eff <= '0;
      b_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ab_eff <= ab_clamped;
            bb_eff <= bb_clamped;
            b_left <= b_count;
            if (kind == CONSECUTIVE) begin
              if (run_len != '0) begin
                state <= RUN_A;
                a     <= 1'b1;
                busy  <= 1'b1;
              end else begin
                state <= FINISH;
                done  <= 1'b1;
              end
            end else begin
              if (b_count != '0) begin
                state <= PULSE_A;
                a     <= 1'b1;
                busy  <= 1'b1;
              end else begin
                state <= FINISH;
                done  <= 1'b1;
              end
            end
          end
        end
        RUN_A: begin
          if (cnt_zero) begin
            state <= FINISH;
            a     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        PULSE_A: begin
          state <= GAP;
          a     <= 1'b0;
        end
        GAP: begin
          if (cnt_zero) begin
            state <= PULSE_B;
            b     <= 1'b1;
          end
        end
        PULSE_B: begin
          b      <= 1'b0;
          b_left <= b_left - LEN_W'(1);
          if (b_left == LEN_W'(1)) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= GAP;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          a     <= 1'b0;
          b     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repetition_pattern_gen.sv
// Directed and randomized checks of repetition_pattern_gen against a per-cycle trace model.
module tb_repetition_pattern_gen;
  import repetition_pkg::*;

  typedef struct packed {
    logic a;
    logic b;
    logic busy;
    logic done;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  repetition_kind_e kind;
  logic [3:0]       run_len;
  logic [3:0]       b_count;
  logic [3:0]       ab_gap;
  logic [3:0]       bb_gap;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;

  int   n_asserts = 0;
  int   n_fail    = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  repetition_pattern_gen #(
    .LEN_W (4),
    .GAP_W (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .kind    (kind),
    .run_len (run_len),
    .b_count (b_count),
    .ab_gap  (ab_gap),
    .bb_gap  (bb_gap),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_cycle(input string tag, input int cyc, input obs_t e);
    chk({tag, "_a"},    cyc, a,    e.a);
    chk({tag, "_b"},    cyc, b,    e.b);
    chk({tag, "_busy"}, cyc, busy, e.busy);
    chk({tag, "_done"}, cyc, done, e.done);
  endtask

  // Expected outputs for cycles 1..done, built straight from the pattern rules.
  function automatic void build_model(input repetition_kind_e k, input int rl, input int bc,
                                      input int abg, input int bbg);
    int ab_len;
    int bb_len;
    exp_q.delete();
    ab_len = (abg < 4) ? 4 : abg;
    bb_len = (bbg < 1) ? 1 : bbg;
    if (k == CONSECUTIVE) begin
      for (int i = 0; i < rl; i++) exp_q.push_back('{a: 1, b: 0, busy: 1, done: 0});
    end else if (bc != 0) begin
      exp_q.push_back('{a: 1, b: 0, busy: 1, done: 0});
      for (int i = 0; i < ab_len; i++) exp_q.push_back('{a: 0, b: 0, busy: 1, done: 0});
      for (int p = 0; p < bc; p++) begin
        exp_q.push_back('{a: 0, b: 1, busy: 1, done: 0});
        if (p != bc - 1)
          for (int i = 0; i < bb_len; i++) exp_q.push_back('{a: 0, b: 0, busy: 1, done: 0});
      end
    end
    exp_q.push_back('{a: 0, b: 0, busy: 0, done: 1});
  endfunction

  task automatic scramble_cfg();
    kind    = repetition_kind_e'($urandom_range(0, 1));
    run_len = 4'($urandom);
    b_count = 4'($urandom);
    ab_gap  = 4'($urandom);
    bb_gap  = 4'($urandom);
  endtask

  // Starts in the current cycle (cycle 0) and returns in the cycle after done.
  task automatic run_pattern(input string tag, input repetition_kind_e k, input int rl,
                             input int bc, input int abg, input int bbg, input int restart_at);
    build_model(k, rl, bc, abg, bbg);
    kind    = k;
    run_len = 4'(rl);
    b_count = 4'(bc);
    ab_gap  = 4'(abg);
    bb_gap  = 4'(bbg);
    start   = 1'b1;
    tick();
    for (int c = 1; c <= exp_q.size(); c++) begin
      scramble_cfg();
      start = (c == restart_at);
      chk_cycle(tag, c, exp_q[c-1]);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    kind    = CONSECUTIVE;
    run_len = '0;
    b_count = '0;
    ab_gap  = '0;
    bb_gap  = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cycle("reset", i, '{a: 0, b: 0, busy: 0, done: 0});
    end
    rst_n = 1'b1;
    tick();
    chk_cycle("idle", 0, '{a: 0, b: 0, busy: 0, done: 0});

    // Run of five with a start retried mid-run, then a second run starting right after done.
    run_pattern("consec5_retry", CONSECUTIVE, 5, 0, 0, 0, 3);
    run_pattern("consec5_b2b",   CONSECUTIVE, 5, 0, 0, 0, -1);
    run_pattern("goto1_gap4",    GOTO, 0, 1, 4, 0, -1);
    run_pattern("goto2_clamp",   GOTO, 0, 2, 0, 0, -1);
    run_pattern("consec0",       CONSECUTIVE, 0, 7, 3, 3, -1);
    run_pattern("goto0",         GOTO, 9, 0, 3, 3, -1);
    // Start held in the done cycle must not launch a new pattern.
    run_pattern("finish_start",  CONSECUTIVE, 2, 0, 0, 0, 3);
    chk_cycle("after_finish", 4, '{a: 0, b: 0, busy: 0, done: 0});
    tick();

    // Reset asserted in cycle 3 of a goto pattern aborts it without a done.
    build_model(GOTO, 0, 1, 4, 0);
    kind    = GOTO;
    b_count = 4'd1;
    ab_gap  = 4'd4;
    bb_gap  = 4'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk_cycle("pre_abort", c, exp_q[c-1]);
      if (c == 3) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    for (int c = 4; c <= 10; c++) begin
      chk_cycle("abort", c, '{a: 0, b: 0, busy: 0, done: 0});
      tick();
    end
    run_pattern("goto1_after_rst", GOTO, 0, 1, 4, 0, -1);

    for (int t = 0; t < 30; t++) begin
      int idle;
      run_pattern("rand", repetition_kind_e'($urandom_range(0, 1)), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 24));
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        chk_cycle("rand_idle", i, '{a: 0, b: 0, busy: 0, done: 0});
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
